key_press_pulser: RTL and testbench
===================================

// Module: key_press_pulser
// PURPOSE
//  Driver end of the per-player L/R press interface feeding the playfield light cells.
//  Conditions one raw player key into a clean 1-cycle press pulse: synchronize, debounce, edge-detect.
//  One instance per player key; press drives the L or R input of every light cell.
//  The light FSMs consume L/R as single-cycle strobes; this block guarantees that contract.
// PARAMETERS
//  SYNC_STAGES      2   flops in the metastability chain (>=2)
//  DEBOUNCE_CYCLES  4   consecutive equal synced samples required to accept a level change (>=1)
//  REPEAT_CYCLES    8   cycles between auto-repeat pulses while held (used only with HOLD_REPEAT_EN)
// PORTS
//  clk      in   1  system clock
//  reset    in   1  asynchronous, active-high; clears all state
//  key_raw  in   1  raw key level, 1 = pressed (top level inverts the active-low board KEY), async to clk
//  press    out  1  1-cycle strobe per accepted press (plus repeats when enabled)
//  held     out  1  debounced key level
// BEHAVIOUR
//  - Reset (async assert): sync chain = 0, state = IDLE, counters = 0, press = 0, held = 0. All outputs registered.
//  - sync_out = last stage of chain; the FSM samples sync_out on every rising edge.
//  - States: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
//      IDLE:         sync_out=1 -> PRESS_WAIT, cnt=1; else stay.
//      PRESS_WAIT:   sync_out=0 -> IDLE, cnt=0 (bounce); cnt reaches DEBOUNCE_CYCLES -> HELD, press=1, held=1.
//      HELD:         sync_out=0 -> RELEASE_WAIT, cnt=1; else stay.
//      RELEASE_WAIT: sync_out=1 -> HELD, cnt=0 (bounce, no new press); cnt reaches DEBOUNCE_CYCLES -> IDLE, held=0.
//  - Latency: first edge sampling key_raw=1 is edge 1; press is high after edge SYNC_STAGES+DEBOUNCE_CYCLES,
//    for exactly one cycle. held falls with the same latency after release. Release never pulses press.
//  - With DEBOUNCE_CYCLES=1, PRESS_WAIT/RELEASE_WAIT last one sample.
//  - cnt width = $clog2(max(DEBOUNCE_CYCLES,REPEAT_CYCLES)+1); cnt saturates and never wraps.
//  - press is never high on two consecutive cycles.
//  - Key held through reset deassertion: treated as a fresh press; one press pulse after the normal latency.
//  - Reset asserted mid-debounce or mid-hold: immediate clear; no pulse is emitted for that press.
// CONFIGURATION
//  - HOLD_REPEAT_EN defined: in HELD, rep_cnt increments every cycle.
//    On reaching REPEAT_CYCLES: press=1 for one cycle, rep_cnt=0.
//    The first repeat comes REPEAT_CYCLES cycles after the initial press.
//    rep_cnt clears on entry to HELD, including a return from RELEASE_WAIT.
//  - HOLD_REPEAT_EN undefined: exactly one press per accepted press; rep_cnt logic absent.
// STRUCTURE
//  - Shared package tug_pkg: key_state_t enum {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT};
//    default constants for SYNC_STAGES, DEBOUNCE_CYCLES and REPEAT_CYCLES.
//  - Sub-module sync_chain #(STAGES): parameterized bit synchronizer with async reset to 0.
//  - Top holds the FSM, the debounce counter and the optional repeat counter.
// TESTING (S=2, D=4, R=8)
//  1. reset=1 for 2 cycles, key_raw=0 -> press=0 and held=0 throughout; deassert reset -> outputs stay 0.
//  2. key_raw 0->1 held for 20 cycles -> press high only after edge 6, held=1 from edge 6;
//     release -> held=0 after edge 6 of release, no press pulse.
//  3. Bounce: key_raw 1 for 3 cycles, 0 for 1, then 1 steady -> no press during the bounce;
//     a single press pulse 6 edges after the final rise.
//  4. Release bounce: in HELD, key_raw 0 for 2 cycles, then 1 -> held stays 1, press stays 0.
//  5. Reset pulse asserted while in PRESS_WAIT -> outputs clear immediately, asynchronously;
//     key still 1 after reset release -> one press pulse 6 edges later.
//  6. HOLD_REPEAT_EN defined, key held 30 cycles -> press at edges 6, 14, 22, 30;
//     undefined -> press at edge 6 only.

Source files
------------

// File: rtl/tug_pkg.sv
// Shared types and default constants for the player key conditioning path.
package tug_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam int unsigned SYNC_STAGES_DEF     = 2;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
    localparam int unsigned REPEAT_CYCLES_DEF   = 8;

    // Counter width able to hold the larger of the debounce and repeat limits.
    function automatic int unsigned cnt_width(input int unsigned deb, input int unsigned rep);
        int unsigned m;
        m = (deb > rep) ? deb : rep;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop bit synchronizer; every stage clears asynchronously to 0.
module sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/key_press_pulser.sv
// Turns one raw player key into a synchronized, debounced, single-cycle press strobe.
// Define HOLD_REPEAT_EN to emit auto-repeat strobes every REPEAT_CYCLES while the key is held.
module key_press_pulser
    import tug_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic press,
    output logic held
);

    localparam int unsigned     CNT_W    = cnt_width(DEBOUNCE_CYCLES, REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_out;
    key_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;

`ifdef HOLD_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] rep_cnt_q;
`endif

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (key_raw),
        .q_o   (sync_out)
    );

    // cnt_q counts consecutive samples at the candidate level; the last one commits the change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            press     <= 1'b0;
            held      <= 1'b0;
`ifdef HOLD_REPEAT_EN
            rep_cnt_q <= '0;
`endif
        end else begin
            press <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sync_out) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync_out) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q >= DEB_LAST) begin
                        state_q   <= HELD;
                        cnt_q     <= '0;
                        press     <= 1'b1;
                        held      <= 1'b1;
`ifdef HOLD_REPEAT_EN
                        rep_cnt_q <= '0;
`endif
                    end else begin
                        cnt_q <= (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!sync_out) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= CNT_ONE;
`ifdef HOLD_REPEAT_EN
                    end else if (rep_cnt_q >= REP_LAST) begin
                        press     <= 1'b1;
                        rep_cnt_q <= '0;
                    end else begin
                        rep_cnt_q <= rep_cnt_q + CNT_ONE;
`endif
                    end
                end
                RELEASE_WAIT: begin
                    // A bounce back to pressed resumes the hold without a new strobe.
                    if (sync_out) begin
                        state_q   <= HELD;
                        cnt_q     <= '0;
`ifdef HOLD_REPEAT_EN
                        rep_cnt_q <= '0;
`endif
                    end else if (cnt_q >= DEB_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        held    <= 1'b0;
                    end else begin
                        cnt_q <= (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_press_pulser.sv
// Directed bench for key_press_pulser: run-length reference model plus hand-computed edge checks.
module tb_key_press_pulser;

    localparam int unsigned S = 2;
    localparam int unsigned D = 4;
    localparam int unsigned R = 8;

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic key_raw = 1'b0;
    logic press;
    logic held;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    key_press_pulser #(
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_CYCLES   (R)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .key_raw (key_raw),
        .press   (press),
        .held    (held)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference: delay raw key by S, accept a new level after D consecutive equal samples.
    logic [S-1:0] pipe_m;
    logic         last_s_m;
    int           run_m;
    logic         lvl_m;
    logic         press_m;
    int           rep_m;

    always @(posedge clk or posedge reset) begin
        logic s;
`ifdef HOLD_REPEAT_EN
        logic prev_s;
`endif
        if (reset) begin
            pipe_m   = '0;
            last_s_m = 1'b0;
            run_m    = 0;
            lvl_m    = 1'b0;
            press_m  = 1'b0;
            rep_m    = 0;
        end else begin
            s      = pipe_m[S-1];
            pipe_m = {pipe_m[S-2:0], key_raw};
`ifdef HOLD_REPEAT_EN
            prev_s = last_s_m;
`endif
            if (s == last_s_m) begin
                if (run_m < 1000) run_m = run_m + 1;
            end else begin
                run_m = 1;
            end
            last_s_m = s;
            press_m  = 1'b0;
            if (s != lvl_m && run_m == int'(D)) begin
                lvl_m   = s;
                press_m = s;
                rep_m   = 0;
            end
`ifdef HOLD_REPEAT_EN
            else if (lvl_m && s) begin
                if (!prev_s) begin
                    rep_m = 0;
                end else begin
                    rep_m = rep_m + 1;
                    if (rep_m == int'(R)) begin
                        press_m = 1'b1;
                        rep_m   = 0;
                    end
                end
            end
`endif
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("model_press", 32'(press), 32'(press_m));
            check("model_held", 32'(held), 32'(lvl_m));
        end
    end

    initial begin
        int press_edges[$];
        int exp_edges[$];

        // 1: reset with key low
        reset   = 1'b1;
        key_raw = 1'b0;
        wait_edges(2);
        checking = 1'b1;
        check("rst_press", 32'(press), 32'd0);
        check("rst_held", 32'(held), 32'd0);
        reset = 1'b0;
        wait_edges(5);
        check("post_rst_press", 32'(press), 32'd0);
        check("post_rst_held", 32'(held), 32'd0);

        // 2: clean press held 20 cycles, then clean release
        key_raw = 1'b1;
        wait_edges(5);
        check("t2_e5_press", 32'(press), 32'd0);
        check("t2_e5_held", 32'(held), 32'd0);
        wait_edges(1);
        check("t2_e6_press", 32'(press), 32'd1);
        check("t2_e6_held", 32'(held), 32'd1);
        wait_edges(1);
        check("t2_e7_press", 32'(press), 32'd0);
        check("t2_e7_held", 32'(held), 32'd1);
        wait_edges(13);
        key_raw = 1'b0;
        wait_edges(5);
        check("t2_rel_e5_held", 32'(held), 32'd1);
        wait_edges(1);
        check("t2_rel_e6_held", 32'(held), 32'd0);
        check("t2_rel_e6_press", 32'(press), 32'd0);
        wait_edges(6);

        // 3: press bounce 1,1,1,0 then steady 1
        key_raw = 1'b1;
        wait_edges(3);
        key_raw = 1'b0;
        wait_edges(1);
        key_raw = 1'b1;
        wait_edges(5);
        check("t3_e5_press", 32'(press), 32'd0);
        check("t3_e5_held", 32'(held), 32'd0);
        wait_edges(1);
        check("t3_e6_press", 32'(press), 32'd1);
        check("t3_e6_held", 32'(held), 32'd1);
        wait_edges(1);
        check("t3_e7_press", 32'(press), 32'd0);

        // 4: release bounce while held
        wait_edges(4);
        key_raw = 1'b0;
        wait_edges(2);
        key_raw = 1'b1;
        wait_edges(10);
        check("t4_held_kept", 32'(held), 32'd1);
        key_raw = 1'b0;
        wait_edges(12);
        check("t4_released", 32'(held), 32'd0);

        // 5: reset during debounce, key stays pressed across reset release
        key_raw = 1'b1;
        wait_edges(4);
        #1 reset = 1'b1;
        #1;
        check("t5_rst_press", 32'(press), 32'd0);
        check("t5_rst_held", 32'(held), 32'd0);
        wait_edges(2);
        reset = 1'b0;
        wait_edges(5);
        check("t5_e5_press", 32'(press), 32'd0);
        wait_edges(1);
        check("t5_e6_press", 32'(press), 32'd1);
        check("t5_e6_held", 32'(held), 32'd1);
        // reset while held clears asynchronously, before any clock edge
        wait_edges(3);
        #1 reset = 1'b1;
        #1;
        check("t5_hold_rst_held", 32'(held), 32'd0);
        key_raw = 1'b0;
        wait_edges(2);
        reset = 1'b0;
        wait_edges(8);
        check("t5_after_press", 32'(press), 32'd0);
        check("t5_after_held", 32'(held), 32'd0);

        // 6: long hold, record strobe edges
        key_raw = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            wait_edges(1);
            if (press === 1'b1) press_edges.push_back(e);
        end
        key_raw = 1'b0;
        wait_edges(12);
`ifdef HOLD_REPEAT_EN
        exp_edges = '{6, 14, 22, 30};
`else
        exp_edges = '{6};
`endif
        check("t6_press_count", 32'(press_edges.size()), 32'(exp_edges.size()));
        for (int i = 0; i < exp_edges.size(); i++) begin
            if (i < press_edges.size()) begin
                check("t6_press_edge", 32'(press_edges[i]), 32'(exp_edges[i]));
            end
        end

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
